// File: rtl/nvram_ioctl.sv
// -----------------------------------------------------------------------------
// nvram_ioctl
//
// Bridges the Williams CMOS (high-score / settings NVRAM, 1024 nibbles) to the
// HPS ioctl channel. While an upload of index NV_INDEX is active, each ioctl_rd
// fetches one nibble from the CMOS RAM second port and returns it zero-extended
// on ioctl_din, stalling the HPS with ioctl_wait while the RAM read is in
// flight. While a download of index NV_INDEX is active, each ioctl_wr writes
// the low nibble of ioctl_dout back into the CMOS. The CPU is held for the
// whole transfer, and nv_dirty tracks whether the CPU has modified the CMOS
// since the last completed upload.
//
// Ports:
//   clk_sys         system clock (12 MHz)
//   reset           asynchronous active-high reset
//   ioctl_upload    HPS upload (core -> HPS) active
//   ioctl_download  HPS download (HPS -> core) active
//   ioctl_index     transfer index
//   ioctl_addr      byte address of the current ioctl access
//   ioctl_rd        one-cycle read request (upload)
//   ioctl_wr        one-cycle write strobe (download)
//   ioctl_dout      download data (only the low nibble is stored)
//   ioctl_din       upload data returned to the HPS
//   ioctl_wait      read in progress, HPS must stall
//   nv_addr         CMOS port-B address
//   nv_rd           CMOS port-B read strobe
//   nv_q            CMOS port-B read data, valid one cycle after nv_rd
//   nv_we           CMOS port-B write enable
//   nv_d            CMOS port-B write data
//   cpu_cmos_we     CPU write to CMOS (pulse)
//   cpu_hold        pauses the CPU during a matching transfer
//   nv_dirty        CMOS changed since the last completed upload
// -----------------------------------------------------------------------------
module nvram_ioctl #(
  parameter int ADDR_W   = 10,
  parameter int NV_INDEX = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] nv_addr,
  output logic              nv_rd,
  input  logic [3:0]        nv_q,
  output logic              nv_we,
  output logic [3:0]        nv_d,
  input  logic              cpu_cmos_we,
  output logic              cpu_hold,
  output logic              nv_dirty
);

  localparam logic [15:0] NV_IDX = 16'(NV_INDEX);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] nv_addr_reg;
  logic              nv_we_reg;
  logic [3:0]        nv_d_reg;
  logic [7:0]        din_reg;
  logic              sel_d1_reg;
  logic              sel_up_d1_reg;
  logic              hold_reg;
  logic              dirty_reg;

  logic sel_up, sel_dn, in_range;
  logic rd_hit, rd_miss, wr_hit;

  // The upper data nibble has no home in the 4-bit CMOS.
  logic unused_dout_hi;
  assign unused_dout_hi = ^ioctl_dout[7:4];

  // Download takes priority: an upload is only selected while no download runs.
  assign sel_up   = ioctl_upload & ~ioctl_download & (ioctl_index == NV_IDX);
  assign sel_dn   = ioctl_download & (ioctl_index == NV_IDX);
  assign in_range = (ioctl_addr[24:ADDR_W] == '0);

  // Reads are only accepted from IDLE; requests arriving mid-read are dropped.
  assign rd_hit  = (state_reg == IDLE) & ioctl_rd & sel_up & in_range;
  assign rd_miss = (state_reg == IDLE) & ioctl_rd & sel_up & ~in_range;
  assign wr_hit  = ioctl_wr & sel_dn & in_range;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rd_hit) state_next = RD_REQ;
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = RD_DONE;
      RD_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      nv_addr_reg   <= '0;
      nv_we_reg     <= 1'b0;
      nv_d_reg      <= 4'h0;
      din_reg       <= 8'hFF;
      sel_d1_reg    <= 1'b0;
      sel_up_d1_reg <= 1'b0;
      hold_reg      <= 1'b0;
      dirty_reg     <= 1'b0;
    end else begin
      // sel_up and sel_dn are exclusive, so a read and a write are never
      // accepted in the same cycle and nv_rd / nv_we cannot overlap.
      nv_we_reg <= wr_hit;
      if (wr_hit) begin
        nv_addr_reg <= ioctl_addr[ADDR_W-1:0];
        nv_d_reg    <= ioctl_dout[3:0];
      end else if (rd_hit) begin
        nv_addr_reg <= ioctl_addr[ADDR_W-1:0];
      end

      // RAM data is valid during RD_WAIT; otherwise ioctl_din holds.
      if (state_reg == RD_WAIT) begin
        din_reg <= {4'h0, nv_q};
      end else if (rd_miss) begin
        din_reg <= 8'hFF;
      end

      // Hold rises one cycle after selection and is stretched two cycles past
      // its end so a write accepted in the last selected cycle still lands.
      sel_d1_reg <= sel_up | sel_dn;
      hold_reg   <= sel_up | sel_dn | sel_d1_reg;

      // A fresh CPU write must never be lost to a simultaneous upload end.
      sel_up_d1_reg <= sel_up;
      if (cpu_cmos_we) begin
        dirty_reg <= 1'b1;
      end else if (sel_up_d1_reg & ~sel_up) begin
        dirty_reg <= 1'b0;
      end
    end
  end

  assign nv_rd      = (state_reg == RD_REQ);
  assign ioctl_wait = (state_reg == RD_REQ) | (state_reg == RD_WAIT);
  assign nv_addr    = nv_addr_reg;
  assign nv_we      = nv_we_reg;
  assign nv_d       = nv_d_reg;
  assign ioctl_din  = din_reg;
  assign cpu_hold   = hold_reg;
  assign nv_dirty   = dirty_reg;

endmodule

// File: tb/tb_nvram_ioctl.sv
// -----------------------------------------------------------------------------
// tb_nvram_ioctl
//
// Directed bench for nvram_ioctl. A behavioural CMOS port-B model (registered
// read) sits on the nv_* port. Stimulus tasks push expected RAM reads, RAM
// writes and upload data into queues; a monitor on the falling clock edge pops
// and compares whenever the DUT strobes nv_rd, nv_we or finishes a read.
// Cycle-exact timing points are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_nvram_ioctl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [15:0] ioctl_index = 16'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        ioctl_rd = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [9:0]  nv_addr;
  logic        nv_rd;
  logic [3:0]  nv_q = 4'h0;
  logic        nv_we;
  logic [3:0]  nv_d;
  logic        cpu_cmos_we = 1'b0;
  logic        cpu_hold;
  logic        nv_dirty;

  logic [3:0]  mem [0:1023];

  int n_chk  = 0;
  int n_fail = 0;

  logic [9:0]  exp_rd_q  [$];
  logic [7:0]  exp_din_q [$];
  logic [13:0] exp_wr_q  [$];
  logic        wait_prev = 1'b0;

  always #5 clk_sys = ~clk_sys;

  nvram_ioctl #(.ADDR_W(10), .NV_INDEX(4)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_upload   (ioctl_upload),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_rd       (ioctl_rd),
    .ioctl_wr       (ioctl_wr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_din      (ioctl_din),
    .ioctl_wait     (ioctl_wait),
    .nv_addr        (nv_addr),
    .nv_rd          (nv_rd),
    .nv_q           (nv_q),
    .nv_we          (nv_we),
    .nv_d           (nv_d),
    .cpu_cmos_we    (cpu_cmos_we),
    .cpu_hold       (cpu_hold),
    .nv_dirty       (nv_dirty)
  );

  // CMOS port-B model: registered read, synchronous write.
  always @(posedge clk_sys) begin
    if (nv_rd) nv_q <= mem[nv_addr];
    if (nv_we) mem[nv_addr] <= nv_d;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk_sys) begin
    if (reset) begin
      wait_prev <= 1'b0;
    end else begin
      if (nv_rd || nv_we) chk("rd_we_overlap", {31'd0, nv_rd & nv_we}, 0);
      if (nv_rd) begin
        if (exp_rd_q.size() == 0) chk("nv_rd_unexpected", {31'd0, nv_rd}, 0);
        else begin
          chk("nv_rd_addr", {22'd0, nv_addr}, {22'd0, exp_rd_q.pop_front()});
          $display("ram rd   addr=%03h", nv_addr);
        end
      end
      if (nv_we) begin
        if (exp_wr_q.size() == 0) chk("nv_we_unexpected", {31'd0, nv_we}, 0);
        else begin
          chk("nv_we_addr_data", {18'd0, nv_addr, nv_d}, {18'd0, exp_wr_q.pop_front()});
          $display("ram wr   addr=%03h d=%h", nv_addr, nv_d);
        end
      end
      if (wait_prev && !ioctl_wait) begin
        if (exp_din_q.size() == 0) chk("rd_done_unexpected", {31'd0, wait_prev}, 0);
        else begin
          chk("ioctl_din", {24'd0, ioctl_din}, {24'd0, exp_din_q.pop_front()});
          $display("upload   din=%02h", ioctl_din);
        end
      end
      wait_prev <= ioctl_wait;
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_sys);
  endtask

  // In-range read; optionally keep ioctl_rd high one extra cycle (must be ignored).
  task automatic rd_ok(input logic [24:0] addr, input logic [7:0] exp, input logic dbl);
    exp_rd_q.push_back(addr[9:0]);
    exp_din_q.push_back(exp);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    step();
    if (dbl) ioctl_addr = addr + 25'd1;
    else ioctl_rd = 1'b0;
    at_neg();
    chk("rd_req_wait", {31'd0, ioctl_wait}, 1);
    chk("rd_req_nv_rd", {31'd0, nv_rd}, 1);
    step();
    ioctl_rd = 1'b0;
    at_neg();
    chk("rd_wait_wait", {31'd0, ioctl_wait}, 1);
    chk("rd_wait_nv_rd", {31'd0, nv_rd}, 0);
    step();
    at_neg();
    chk("rd_done_wait", {31'd0, ioctl_wait}, 0);
    chk("rd_done_din", {24'd0, ioctl_din}, {24'd0, exp});
    step();
  endtask

  task automatic rd_oor(input logic [24:0] addr);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    at_neg();
    chk("oor_din", {24'd0, ioctl_din}, 32'hFF);
    chk("oor_wait", {31'd0, ioctl_wait}, 0);
    step();
    at_neg();
    chk("oor_wait2", {31'd0, ioctl_wait}, 0);
    $display("upload   oor addr=%07h din=%02h", addr, ioctl_din);
    step();
  endtask

  task automatic rd_ignored(input logic [24:0] addr, input logic [7:0] keep);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("ign_wait", {31'd0, ioctl_wait}, 0);
      chk("ign_din", {24'd0, ioctl_din}, {24'd0, keep});
      step();
    end
    $display("upload   ignored addr=%07h", addr);
  endtask

  task automatic wr(input logic [24:0] addr, input logic [7:0] dout, input logic exp_we);
    if (exp_we) exp_wr_q.push_back({addr[9:0], dout[3:0]});
    ioctl_addr = addr;
    ioctl_dout = dout;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr = 1'b0;
    at_neg();
    chk("wr_we", {31'd0, nv_we}, {31'd0, exp_we});
    step();
    at_neg();
    chk("wr_we_single", {31'd0, nv_we}, 0);
    $display("download addr=%07h dout=%02h idx=%0d we=%0d", addr, dout, ioctl_index, exp_we);
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    mem[10'h005] = 4'hA;
    mem[10'h3FF] = 4'h3;

    // Reset state
    repeat (3) @(posedge clk_sys);
    at_neg();
    chk("rst_din", {24'd0, ioctl_din}, 32'hFF);
    chk("rst_wait", {31'd0, ioctl_wait}, 0);
    chk("rst_nv_rd", {31'd0, nv_rd}, 0);
    chk("rst_nv_we", {31'd0, nv_we}, 0);
    chk("rst_nv_addr", {22'd0, nv_addr}, 0);
    chk("rst_nv_d", {28'd0, nv_d}, 0);
    chk("rst_hold", {31'd0, cpu_hold}, 0);
    chk("rst_dirty", {31'd0, nv_dirty}, 0);
    step();
    reset = 1'b0;

    // CPU write marks CMOS dirty
    cpu_cmos_we = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
    at_neg();
    chk("dirty_set", {31'd0, nv_dirty}, 1);
    step();

    // Upload start: hold rises one cycle later
    ioctl_index  = 16'd4;
    ioctl_upload = 1'b1;
    at_neg();
    chk("hold_not_yet", {31'd0, cpu_hold}, 0);
    step();
    at_neg();
    chk("hold_up", {31'd0, cpu_hold}, 1);
    step();
    rd_ok(25'h005, 8'h0A, 1'b1);
    rd_oor(25'h400);
    rd_ok(25'h3FF, 8'h03, 1'b0);

    // Upload ends: dirty clears, hold lingers two cycles
    ioctl_upload = 1'b0;
    at_neg();
    chk("end_dirty_m0", {31'd0, nv_dirty}, 1);
    chk("end_hold_m0", {31'd0, cpu_hold}, 1);
    step();
    at_neg();
    chk("end_dirty_m1", {31'd0, nv_dirty}, 0);
    chk("end_hold_m1", {31'd0, cpu_hold}, 1);
    step();
    at_neg();
    chk("end_hold_m2", {31'd0, cpu_hold}, 0);
    step();

    // Set and clear collide: set wins
    ioctl_upload = 1'b1;
    step();
    step();
    ioctl_upload = 1'b0;
    cpu_cmos_we  = 1'b1;
    step();
    cpu_cmos_we = 1'b0;
    at_neg();
    chk("dirty_collision", {31'd0, nv_dirty}, 1);
    step();
    step();

    // Download
    ioctl_download = 1'b1;
    wr(25'h3FF, 8'h5C, 1'b1);
    ioctl_index = 16'd0;
    wr(25'h3FF, 8'h51, 1'b0);
    ioctl_index = 16'd4;
    wr(25'h400, 8'h5E, 1'b0);
    at_neg();
    chk("dirty_kept_dl", {31'd0, nv_dirty}, 1);
    step();

    // Upload and download both high: read ignored, write honoured
    ioctl_upload = 1'b1;
    rd_ignored(25'h005, 8'h03);
    wr(25'h005, 8'h37, 1'b1);
    ioctl_upload   = 1'b0;
    ioctl_download = 1'b0;
    at_neg();
    chk("both_hold_m0", {31'd0, cpu_hold}, 1);
    step();
    at_neg();
    chk("both_hold_m1", {31'd0, cpu_hold}, 1);
    step();
    at_neg();
    chk("both_hold_m2", {31'd0, cpu_hold}, 0);
    step();

    // Read back the downloaded nibbles
    ioctl_upload = 1'b1;
    step();
    rd_ok(25'h005, 8'h07, 1'b0);
    rd_ok(25'h3FF, 8'h0C, 1'b0);

    // Reset during RD_WAIT aborts the read
    exp_rd_q.push_back(10'h005);
    ioctl_addr = 25'h005;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("abort_wait", {31'd0, ioctl_wait}, 0);
    chk("abort_din", {24'd0, ioctl_din}, 32'hFF);
    at_neg();
    chk("abort_nv_rd", {31'd0, nv_rd}, 0);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("abort_no_done", {24'd0, ioctl_din}, 32'hFF);
      step();
    end
    $display("upload   aborted by reset");
    rd_ok(25'h005, 8'h07, 1'b0);
    ioctl_upload = 1'b0;
    repeat (3) step();

    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("din_q_empty", exp_din_q.size(), 0);
    chk("wr_q_empty", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
